// File: rtl/serial_mag_compare_ctrl_pkg.sv
// Shared definitions for the serial magnitude comparator: state encoding and width check.
package serial_mag_compare_ctrl_pkg;

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_SHIFT = 2'd1;
  localparam logic [STATE_W-1:0] ST_DONE  = 2'd2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    DONE  = ST_DONE
  } state_t;

  localparam int unsigned WIDTH_MIN = 2;

  // Operands narrower than two bits leave nothing to sequence.
  function automatic bit width_ok(input int unsigned w);
    return (w >= WIDTH_MIN);
  endfunction

endpackage

// File: rtl/serial_mag_compare_ctrl_bit_compare_cell.sv
// Single-bit magnitude compare cell; exactly one output is high for any input pair.
module bit_compare_cell
  import serial_mag_compare_ctrl_pkg::*;
(
  input  logic a,
  input  logic b,
  output logic gt,
  output logic lt,
  output logic eq
);

  // Pure decode of the two operand bits.
  always_comb begin
    gt = a & ~b;
    lt = ~a & b;
    eq = ~(a ^ b);
  end

endmodule

// File: rtl/serial_mag_compare_ctrl.sv
// Sequences one shared bit_compare_cell over two operands, MSB first, with early exit
// on the first differing bit and a start/done handshake.
module serial_mag_compare_ctrl
  import serial_mag_compare_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  if (!width_ok(WIDTH)) begin : g_width_chk
    $error("serial_mag_compare_ctrl: WIDTH must be at least 2");
  end

  state_t             state;
  logic [WIDTH-1:0]   sa;
  logic [WIDTH-1:0]   sb;
  logic [CNT_W-1:0]   cnt;
  logic               cell_gt;
  logic               cell_lt;
  logic               cell_eq;

  bit_compare_cell u_cell (
    .a  (sa[WIDTH-1]),
    .b  (sb[WIDTH-1]),
    .gt (cell_gt),
    .lt (cell_lt),
    .eq (cell_eq)
  );

  // Control FSM with the operand shifters, bit counter and registered result flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      gt    <= 1'b0;
      lt    <= 1'b0;
      eq    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            cnt   <= CNT_W'(WIDTH - 1);
            gt    <= 1'b0;
            lt    <= 1'b0;
            eq    <= 1'b0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (cell_gt) begin
            gt    <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else if (cell_lt) begin
            lt    <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else if (cell_eq && (cnt == '0)) begin
            eq    <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            sa  <= {sa[WIDTH-2:0], 1'b0};
            sb  <= {sb[WIDTH-2:0], 1'b0};
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mag_compare_ctrl.sv
// Randomized and directed checks of serial_mag_compare_ctrl against an arithmetic model.
module tb_serial_mag_compare_ctrl;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         gt;
  logic         lt;
  logic         eq;

  int n_checks;
  int n_errors;

  serial_mag_compare_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .gt    (gt),
    .lt    (lt),
    .eq    (eq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: result flags {gt,lt,eq} from unsigned arithmetic.
  function automatic logic [2:0] exp_res(input logic [W-1:0] x, input logic [W-1:0] y);
    int unsigned xi = int'(x);
    int unsigned yi = int'(y);
    return {xi > yi, xi < yi, xi == yi};
  endfunction

  // Model: decision edge index = W - (highest differing bit position), or W if equal.
  function automatic int exp_dec(input logic [W-1:0] x, input logic [W-1:0] y);
    int unsigned d = int'(x ^ y);
    int          msb = -1;
    while (d != 0) begin
      d = d / 2;
      msb++;
    end
    return (msb < 0) ? int'(W) : int'(W) - msb;
  endfunction

  function automatic logic [2:0] res_now();
    return {gt, lt, eq};
  endfunction

  // One full compare: start accepted at the next edge, optional operand scrambling after capture.
  task automatic run_compare(input logic [W-1:0] ta, input logic [W-1:0] tb_op, input bit scramble);
    int         dec;
    int         lat;
    bit         got;
    logic [2:0] er;
    dec = exp_dec(ta, tb_op);
    er  = exp_res(ta, tb_op);
    @(negedge clk);
    a     = ta;
    b     = tb_op;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("accept_busy", 32'(busy), 32'd1);
    check("accept_done", 32'(done), 32'd0);
    check("accept_clear", 32'(res_now()), 32'd0);
    if (scramble) begin
      a = W'($urandom);
      b = W'($urandom);
    end
    lat = 0;
    got = 1'b0;
    while (!got && lat < int'(2 * W + 4)) begin
      @(negedge clk);
      lat++;
      if (done) got = 1'b1;
      else check("busy_shift", 32'(busy), 32'd1);
    end
    if (!got) begin
      check("timeout", 32'd0, 32'd1);
    end else begin
      check("latency", 32'(lat), 32'(dec));
      check("result", 32'(res_now()), 32'(er));
      check("busy_done", 32'(busy), 32'd1);
    end
    @(negedge clk);
    check("post_done", 32'(done), 32'd0);
    check("post_busy", 32'(busy), 32'd0);
    check("post_hold", 32'(res_now()), 32'(er));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    start    = 1'b1;
    a        = 8'h55;
    b        = 8'h33;

    // Reset held for two edges with start asserted.
    repeat (2) begin
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_res", 32'(res_now()), 32'd0);
    end
    start = 1'b0;
    rst_n = 1'b1;

    // Directed cases, including worst case and both early exits.
    run_compare(8'hA5, 8'hA5, 1'b0);
    run_compare(8'h80, 8'h7F, 1'b0);
    run_compare(8'h01, 8'h00, 1'b0);
    run_compare(8'h3C, 8'h3D, 1'b0);
    run_compare(8'h10, 8'h20, 1'b0);
    run_compare(8'h00, 8'h00, 1'b0);
    run_compare(8'hFF, 8'hFE, 1'b1);

    // start held high: second request accepted only once back in IDLE.
    @(negedge clk);
    a     = 8'hFF;
    b     = 8'h00;
    start = 1'b1;
    @(negedge clk);
    check("hold_e0_busy", 32'(busy), 32'd1);
    a = 8'h00;
    b = 8'hFF;
    @(negedge clk);
    check("hold_e1_done", 32'(done), 32'd1);
    check("hold_e1_res", 32'(res_now()), 32'd4);
    a = 8'hFF;
    b = 8'h00;
    @(negedge clk);
    check("hold_e2_busy", 32'(busy), 32'd0);
    check("hold_e2_done", 32'(done), 32'd0);
    @(negedge clk);
    check("hold_e3_busy", 32'(busy), 32'd1);
    check("hold_e3_clear", 32'(res_now()), 32'd0);
    @(negedge clk);
    check("hold_e4_done", 32'(done), 32'd1);
    check("hold_e4_res", 32'(res_now()), 32'd4);
    start = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the middle of an equal compare: no done pulse, then normal operation.
    a     = 8'hA5;
    b     = 8'hA5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("mid_busy", 32'(busy), 32'd1);
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_res", 32'(res_now()), 32'd0);
    rst_n = 1'b1;
    repeat (W) begin
      @(negedge clk);
      check("mid_no_done", 32'(done), 32'd0);
    end
    run_compare(8'hA5, 8'hA5, 1'b0);

    // Randomized operands, biased toward equal and near-equal pairs.
    for (int i = 0; i < 60; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      int unsigned  mode;
      ra   = W'($urandom);
      mode = $urandom_range(3);
      if (mode == 0)      rb = ra;
      else if (mode == 1) rb = ra ^ W'(1 << $urandom_range(W - 1));
      else                rb = W'($urandom);
      run_compare(ra, rb, 1'($urandom_range(1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
